// File: rtl/logic_alu_pkg.sv
// logic_alu_pkg: opcode/state enums and the shared ALU evaluation function.
// Used by logic_alu_arbiter (optional build macro: LOGIC_ALU_XCHECK_EN).
package logic_alu_pkg;

    localparam int MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        OP_AND,
        OP_OR,
        OP_ADD,
        OP_XOR
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } alu_state_e;

    // Operands arrive zero-extended, so the ADD carry lands in the bit
    // just above the caller's WIDTH and survives truncation to WIDTH+1.
    function automatic logic [MAX_WIDTH:0] alu_eval(
        input alu_op_e              op,
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b
    );
        logic [MAX_WIDTH:0] r;
        case (op)
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_XOR:  r = {1'b0, a ^ b};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_alu_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, searching upward from pointer+1.
// Ports: req/pointer/enable in; one-hot grant and encoded grant_idx out.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  pointer,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic              found;
    int                sel;
    int                idx;

    // Rotate so bit 0 of rot is requester pointer+1; lowest set bit wins.
    assign dbl = {req, req} >> (int'(pointer) + 1);
    assign rot = dbl[NREQ-1:0];

    always_comb begin
        found     = 1'b0;
        sel       = 0;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                sel   = j;
            end
        end
        if (enable && found) begin
            idx       = (int'(pointer) + 1 + sel) % NREQ;
            grant     = NREQ'(1) << idx;
            grant_idx = IDW'(idx);
        end
    end

endmodule

// File: rtl/logic_alu_arbiter.sv
// logic_alu_arbiter: one registered AND/OR/ADD/XOR unit shared by NREQ requesters.
// Ports: req_valid/ready/op/a/b per requester; rsp_valid/ready/data/id/err. Macro: LOGIC_ALU_XCHECK_EN.
module logic_alu_arbiter
    import logic_alu_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [2*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH:0]        rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_err
);

    alu_state_e       state_q;
    alu_state_e       state_d;
    logic [IDW-1:0]   ptr_q;
    alu_op_e          op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDW-1:0]   id_q;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_idx;
    logic             arb_en;
    logic             accept;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH:0]   result;

    // rst_n gates the grant so req_ready is 0 while reset is held.
    assign arb_en = (state_q == S_IDLE) && rst_n;
    assign accept = |grant;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req_valid),
        .pointer   (ptr_q),
        .enable    (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_op = req_op[2*i +: 2];
                sel_a  = req_a[WIDTH*i +: WIDTH];
                sel_b  = req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    assign result = (WIDTH+1)'(alu_eval(op_q, MAX_WIDTH'(a_q), MAX_WIDTH'(b_q)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = S_EXEC;
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = grant;
        rsp_valid = (state_q == S_RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= IDW'(NREQ - 1);
            op_q  <= OP_AND;
            a_q   <= '0;
            b_q   <= '0;
            id_q  <= '0;
        end else if (state_q == S_IDLE && accept) begin
            ptr_q <= grant_idx;
            op_q  <= alu_op_e'(sel_op);
            a_q   <= sel_a;
            b_q   <= sel_b;
            id_q  <= grant_idx;
        end
    end

`ifdef LOGIC_ALU_XCHECK_EN
    logic xerr;
    assign xerr = ((^a_q) === 1'bx) || ((^b_q) === 1'bx) ||
                  ((^op_q) === 1'bx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_id   <= '0;
            rsp_err  <= 1'b0;
        end else if (state_q == S_EXEC) begin
            rsp_data <= xerr ? '0 : result;
            rsp_id   <= id_q;
            rsp_err  <= xerr;
        end
    end
`else
    assign rsp_err = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_id   <= '0;
        end else if (state_q == S_EXEC) begin
            rsp_data <= result;
            rsp_id   <= id_q;
        end
    end
`endif

endmodule
